// File: rtl/tt_um_not_tester.sv
// Stimulus/response checker for an 8-bit inverter: LFSR vectors on uo_out, checks ~vector on ui_in.
// Optional checker self-test via macro NOT_TESTER_FAULT_INJECT_EN (uio_in[1] flips expected bit 0).
module tt_um_not_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_VECTORS   = 255,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned VW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0] LAST_VEC    = VW'(NUM_VECTORS - 1);
  localparam logic [CW-1:0] ERR_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [VW-1:0] pat, pat_d;
  logic [VW-1:0] uo_d;
  logic [VW-1:0] vec_cnt, vec_cnt_d;
  logic [CW-1:0] settle_cnt, settle_d;
  logic [CW-1:0] err_cnt, err_d;
  logic          done, done_d;
  logic          pass, pass_d;
  logic          start_q;

  logic          start_edge_c;
  logic [VW-1:0] pat_next_c;
  logic [VW-1:0] expected_c;
  logic          mismatch_c;
  logic [CW-1:0] err_inc_c;
  logic          unused_c;

  assign start_edge_c = uio_in[0] & ~start_q;
  assign pat_next_c   = {pat[6:0], pat[7] ^ pat[5] ^ pat[4] ^ pat[3]};

`ifdef NOT_TESTER_FAULT_INJECT_EN
  // Flipping bit 0 of the expectation makes a healthy DUT look faulty.
  assign expected_c = ~pat ^ {7'b0, uio_in[1]};
  assign unused_c   = ^uio_in[7:2];
`else
  assign expected_c = ~pat;
  assign unused_c   = ^uio_in[7:1];
`endif

  assign mismatch_c = (ui_in != expected_c);
  assign err_inc_c  = (mismatch_c && (err_cnt != ERR_MAX)) ? err_cnt + CW'(1) : err_cnt;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    pat_d     = pat;
    uo_d      = uo_out;
    vec_cnt_d = vec_cnt;
    settle_d  = settle_cnt;
    err_d     = err_cnt;
    done_d    = done;
    pass_d    = pass;
    case (state)
      IDLE, DONE: begin
        if (start_edge_c) begin
          pat_d     = SEED;
          uo_d      = SEED;
          vec_cnt_d = '0;
          err_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          settle_d  = SETTLE_INIT;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        uo_d = pat;
        if (settle_cnt == '0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_cnt - CW'(1);
        end
      end
      CHECK: begin
        err_d = err_inc_c;
        if (vec_cnt == LAST_VEC) begin
          state_d = DONE;
          uo_d    = '0;
          done_d  = 1'b1;
          pass_d  = (err_inc_c == '0);
        end else begin
          vec_cnt_d = vec_cnt + VW'(1);
          pat_d     = pat_next_c;
          uo_d      = pat_next_c;
          settle_d  = SETTLE_INIT;
          state_d   = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      uo_out     <= '0;
      pat        <= SEED;
      vec_cnt    <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      start_q    <= 1'b0;
    end else if (ena) begin
      state      <= state_d;
      uo_out     <= uo_d;
      pat        <= pat_d;
      vec_cnt    <= vec_cnt_d;
      settle_cnt <= settle_d;
      err_cnt    <= err_d;
      done       <= done_d;
      pass       <= pass_d;
      start_q    <= uio_in[0];
    end
  end

  assign uio_out = {err_cnt, pass, done, 2'b00};
  assign uio_oe  = 8'b1111_1100;

endmodule

// File: tb/tb_tt_um_not_tester.sv
// Scoreboard bench for tt_um_not_tester with a behavioural inverter/fault model.
module tb_tt_um_not_tester;

`ifdef NOT_TESTER_FAULT_INJECT_EN
  localparam bit FI_EN = 1'b1;
`else
  localparam bit FI_EN = 1'b0;
`endif
  localparam logic [7:0]  SEED    = 8'hA5;
  localparam int unsigned NVEC    = 255;
  localparam int unsigned RUN_CYC = 765;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic [7:0] stuck0, stuck1;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic        pass;
    logic [3:0]  err;
  } res_t;

  logic [7:0] exp_vec[$];
  res_t       exp_res[$];
  bit         dwell_chk = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inverter under test, with optional stuck-at bits
  assign ui_in = (~uo_out & ~stuck0) | stuck1;

  tt_um_not_tester dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  function automatic logic [7:0] lfsr(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  function automatic logic [7:0] vec_at(input int unsigned idx);
    logic [7:0] v = SEED;
    for (int i = 0; i < int'(idx); i++) v = lfsr(v);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected vector stream and final result for one full run
  task automatic run_model(input bit fi, input int unsigned extra);
    logic [7:0] v = SEED;
    logic [7:0] want;
    int unsigned err = 0;
    for (int i = 0; i < int'(NVEC); i++) begin
      exp_vec.push_back(v);
      want = ~v ^ {7'b0, fi & FI_EN};
      if ((((~v & ~stuck0) | stuck1) != want) && err < 15) err++;
      v = lfsr(v);
    end
    exp_res.push_back('{cyc + 1 + RUN_CYC + extra, (err == 0), 4'(err)});
  endtask

  task automatic start_run(input bit fi, input int unsigned extra, input bit dw);
    dwell_chk = dw;
    uio_in[1] = fi;
    run_model(fi, extra);
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    uio_in[0] = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    while (!uio_out[2] && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!uio_out[2]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, n);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops expected vectors on each new uo_out value, results on done rising
  logic [7:0]  prev_uo = 8'h00;
  logic        prev_done = 1'b0;
  int unsigned dwell = 0;
  always @(negedge clk) begin
    res_t r;
    if (uo_out !== prev_uo) begin
      if (prev_uo != 8'h00 && dwell_chk) check("dwell", 32'(dwell), 32'd3);
      if (uo_out != 8'h00) begin
        if (exp_vec.size() == 0) check("vec_unexpected", 32'(uo_out), 32'd0);
        else check("vec", 32'(uo_out), 32'(exp_vec.pop_front()));
      end
      dwell = 1;
    end else begin
      dwell++;
    end
    prev_uo = uo_out;
    if (uio_out[2] && !prev_done) begin
      if (exp_res.size() == 0) begin
        check("done_unexpected", 32'(uio_out[2]), 32'd0);
      end else begin
        r = exp_res.pop_front();
        check("done_cycle", cyc, r.cyc);
        check("pass", 32'(uio_out[3]), 32'(r.pass));
        check("err_cnt", 32'(uio_out[7:4]), 32'(r.err));
        check("uo_at_done", 32'(uo_out), 32'd0);
        check("uio_out_lo", 32'(uio_out[1:0]), 32'd0);
      end
    end
    prev_done = uio_out[2];
  end

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    uio_in = 8'h00;
    stuck0 = 8'h00;
    stuck1 = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_uo_out", 32'(uo_out), 32'd0);
    check("rst_uio_out", 32'(uio_out), 32'd0);
    check("uio_oe", 32'(uio_oe), 32'hFC);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Ideal inverter
    start_run(1'b0, 0, 1'b1);
    wait_done("ideal");

    // Bit 0 stuck at 0
    stuck0 = 8'h01;
    start_run(1'b0, 0, 1'b1);
    wait_done("stuck0");
    stuck0 = 8'h00;

    // Start edge at vector 10 is ignored
    start_run(1'b0, 0, 1'b1);
    repeat (31) @(posedge clk); #1;
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    uio_in[0] = 1'b0;
    wait_done("midstart");

    // Reset at vector 20
    start_run(1'b0, 0, 1'b0);
    repeat (61) @(posedge clk); #1;
    check("vec20_before_rst", 32'(uo_out), 32'(vec_at(20)));
    rst_n = 1'b0;
    exp_vec.delete();
    exp_res.delete();
    #1;
    check("midrst_uo_out", 32'(uo_out), 32'd0);
    check("midrst_done", 32'(uio_out[2]), 32'd0);
    check("midrst_err", 32'(uio_out[7:4]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("idle_uo_out", 32'(uo_out), 32'd0);
    check("idle_done", 32'(uio_out[2]), 32'd0);

    // ena low for 50 cycles at vector 33
    start_run(1'b0, 50, 1'b0);
    repeat (100) @(posedge clk); #1;
    ena = 1'b0;
    repeat (50) @(posedge clk); #1;
    check("frozen_uo_out", 32'(uo_out), 32'(vec_at(33)));
    check("frozen_done", 32'(uio_out[2]), 32'd0);
    ena = 1'b1;
    wait_done("ena_hold");

    // Fault-inject request with an ideal inverter
    start_run(1'b1, 0, 1'b1);
    wait_done("fault_inject");

    // Randomized inverter faults and fault-inject requests
    for (int k = 0; k < 4; k++) begin
      stuck0 = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      stuck1 = ($urandom_range(0, 2) == 0) ? (8'($urandom) & ~stuck0) : 8'h00;
      start_run(1'($urandom_range(0, 1)), 0, 1'b1);
      wait_done("random");
    end

    check("vec_queue_empty", 32'(exp_vec.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_not_tester.md
Name: tt_um_not_tester

Overview:
- Self-checking stimulus and response block for an 8-bit inverter DUT: it drives the other end of the NOT-gate interface.
- A maximal-length LFSR generates a vector on uo_out, waits for the DUT to settle, then samples the DUT response on ui_in.
- Each response is compared against the bitwise inverse of the driven vector, and mismatches are counted.
- It sits in the standard tile wrapper and reports done, pass and a saturating error count on uio_out.

Parameters:
- SETTLE_CYCLES, 2, cycles between a vector appearing on uo_out and the CHECK cycle; legal range 1..15.
- NUM_VECTORS, 255, vectors per run; legal range 1..255.
- SEED, 8'hA5, LFSR start value; must be nonzero.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  tile enable; when low, all state holds
- ui_in  in  8  DUT response (expected ~vector)
- uo_out  out  8  stimulus vector to DUT
- uio_in  in  8  [0]=start (rising edge), [1]=fault inject (see Optional Feature), [7:2] ignored
- uio_out  out  8  [1:0]=0, [2]=done, [3]=pass, [7:4]=err_cnt
- uio_oe  out  8  constant 8'b1111_1100

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, uo_out=8'h00, pat=SEED, vec_cnt=0, settle_cnt=0, err_cnt=0.
  - done=0, pass=0, start_q=0.
- start_q registers uio_in[0] every enabled cycle. A start edge is uio_in[0]=1 with start_q=0.
- ena=0: no register changes except asynchronous reset; outputs hold their values.
- LFSR (Fibonacci), shift left: next = {pat[6:0], pat[7]^pat[5]^pat[4]^pat[3]}. Period 255. Sequence from A5 is A5, 4A, 95, ...
- IDLE:
  - On start edge: pat=SEED, vec_cnt=0, err_cnt=0, done=0, pass=0, settle_cnt=SETTLE_CYCLES-1, go to SETTLE.
  - uo_out=SEED, registered on the same edge.
- SETTLE:
  - uo_out=pat.
  - If settle_cnt==0, go to CHECK; else decrement settle_cnt.
- CHECK (one cycle):
  - On the closing edge, compare ui_in with ~pat.
  - Any bit mismatch increments err_cnt, saturating at 15.
  - If vec_cnt==NUM_VECTORS-1: go to DONE, uo_out=8'h00, done=1, pass=(err_cnt_next==0).
  - Else: vec_cnt++, pat=LFSR(pat), uo_out=LFSR(pat), settle_cnt=SETTLE_CYCLES-1, go to SETTLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles on uo_out.
  - ui_in is sampled SETTLE_CYCLES+1 edges after the vector appears.
  - A full run takes NUM_VECTORS*(SETTLE_CYCLES+1) cycles after the start edge.
- DONE:
  - done, pass and err_cnt hold.
  - A start edge behaves exactly as in IDLE (restart).
- A start edge in SETTLE or CHECK is ignored; the run continues.
- Reset mid-run: immediate return to reset values; no partial results are retained.
- uio_out[1:0]=0 always; uio_oe is constant.

Optional Feature:
- Macro NOT_TESTER_FAULT_INJECT_EN.
- Defined: when uio_in[1]=1 in CHECK, the expected value becomes ~pat ^ 8'h01. A correct DUT then produces one error per vector, which self-tests the checker.
- Undefined: uio_in[1] is ignored; expected is always ~pat.

Test Plan:
- Ideal inverter model (ui_in=~uo_out, combinational), pulse start, defaults:
  - uo_out shows A5, 4A, 95 in order, 3 cycles each.
  - done=1 exactly 765 cycles after the start edge.
  - pass=1, err_cnt=0, uo_out=00.
- Inverter with ui_in[0] stuck at 0: done=1, pass=0, err_cnt saturates at 15 (more than 15 of the 255 vectors have pat[0]=0).
- Mid-run checks:
  - Start edge at vector 10 is ignored; completion time is unchanged.
  - rst_n low at vector 20 immediately forces uo_out=00, done=0, err_cnt=0; state=IDLE after release.
- ena held low for 50 cycles mid-run: uo_out and counters frozen; run completes 50 cycles late with pass=1.
- With NOT_TESTER_FAULT_INJECT_EN defined, ideal inverter, uio_in[1]=1: err_cnt=15, pass=0.
  - With the macro undefined, same stimulus gives pass=1.
  - Restart from DONE clears err_cnt and reloads SEED.
